// File: rtl/dcarb_pkg.sv
// Shared types for the D-cache port arbiter: FSM states, request owner,
// and a helper that names the owner of the request outstanding in a state.
package dcarb_pkg;

    localparam int unsigned DCARB_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        CORE_WAIT,
        WALK_ISSUE,
        WALK_WAIT
    } dcarb_state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_MMU
    } owner_e;

    // Only the two wait states hold an outstanding request; the walker owns it in WALK_WAIT.
    function automatic owner_e owner_of(input dcarb_state_e s);
        return (s == CORE_WAIT) ? OWN_CORE : OWN_MMU;
    endfunction

endpackage

// File: rtl/dcarb_watchdog.sv
// Watchdog for the single outstanding D-cache request: counts wait cycles
// since the last accept and raises a sticky flag once the limit is reached.
module dcarb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    input  logic waiting,
    output logic timeout
);

    logic [31:0] count;
    logic [31:0] count_inc;

    assign count_inc = count + 32'd1;

    // The flag sets on the same edge the counter reaches the limit and never clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (accept) begin
            count <= '0;
        end else if (waiting) begin
            count <= count_inc;
            if (count_inc >= TIMEOUT_CYCLES) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the D-cache request port between the core LSU and the MMU walker.
// Optional watchdog built when DCARB_WATCHDOG_EN is defined.
module dcache_port_arbiter
   import dcarb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        core_req_valid,
   input  logic [63:0] core_req_addr,
   input  logic        core_req_we,
   input  logic [63:0] core_req_wdata,
   output logic        core_req_ready,
   output logic        core_resp_valid,
   output logic [63:0] core_resp_data,
   input  logic        mmu_use_dcache,
   input  logic [63:0] mmu_req_addr,
   output logic        mmu_resp_valid,
   output logic [63:0] mmu_resp_data,
   output logic        dc_req_valid,
   output logic [63:0] dc_req_addr,
   output logic        dc_req_we,
   output logic [63:0] dc_req_wdata,
   output logic        dc_req_phys,
   input  logic        dc_req_ready,
   input  logic        dc_resp_valid,
   input  logic [63:0] dc_resp_data,
   output logic        arb_timeout
);

   dcarb_state_e state;
   dcarb_state_e state_next;
   owner_e       resp_owner;
   logic         walker_drive;
   logic         core_drive;

   assign resp_owner = owner_of(state);

   // State register; asynchronous reset returns the arbiter to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Responses arriving in IDLE or WALK_ISSUE have no owner and are dropped.
   always_comb begin
      state_next      = state;
      walker_drive    = 1'b0;
      core_drive      = 1'b0;
      core_req_ready  = 1'b0;
      core_resp_valid = 1'b0;
      core_resp_data  = '0;
      mmu_resp_valid  = 1'b0;
      mmu_resp_data   = '0;

      case (state)
         IDLE: begin
            if (mmu_use_dcache) begin
               walker_drive = 1'b1;
               state_next   = dc_req_ready ? WALK_WAIT : WALK_ISSUE;
            end else if (core_req_valid) begin
               core_drive     = 1'b1;
               core_req_ready = dc_req_ready;
               if (dc_req_ready) begin
                  state_next = CORE_WAIT;
               end
            end
         end
         WALK_ISSUE: begin
            if (!mmu_use_dcache) begin
               state_next = IDLE;
            end else begin
               walker_drive = 1'b1;
               if (dc_req_ready) begin
                  state_next = WALK_WAIT;
               end
            end
         end
         CORE_WAIT, WALK_WAIT: begin
            if (dc_resp_valid) begin
               if (resp_owner == OWN_CORE) begin
                  core_resp_valid = 1'b1;
                  core_resp_data  = dc_resp_data;
                  state_next      = IDLE;
               end else begin
                  mmu_resp_valid = mmu_use_dcache;
                  mmu_resp_data  = mmu_use_dcache ? dc_resp_data : '0;
                  state_next     = mmu_use_dcache ? WALK_ISSUE : IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (reset) begin
         walker_drive    = 1'b0;
         core_drive      = 1'b0;
         core_req_ready  = 1'b0;
         core_resp_valid = 1'b0;
         core_resp_data  = '0;
         mmu_resp_valid  = 1'b0;
         mmu_resp_data   = '0;
      end
   end

   // Walker requests are always physical reads; write fields are forced to zero.
   always_comb begin
      dc_req_valid = walker_drive | core_drive;
      dc_req_addr  = '0;
      dc_req_we    = 1'b0;
      dc_req_wdata = '0;
      dc_req_phys  = 1'b0;
      if (walker_drive) begin
         dc_req_addr = mmu_req_addr;
         dc_req_phys = 1'b1;
      end else if (core_drive) begin
         dc_req_addr  = core_req_addr;
         dc_req_we    = core_req_we;
         dc_req_wdata = core_req_wdata;
      end
   end

`ifdef DCARB_WATCHDOG_EN
   dcarb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .accept (dc_req_valid && dc_req_ready),
      .waiting((state == CORE_WAIT) || (state == WALK_WAIT)),
      .timeout(arb_timeout)
   );
`else
   assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a model.
module tb_dcache_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req_valid;
   logic [63:0] core_req_addr;
   logic        core_req_we;
   logic [63:0] core_req_wdata;
   logic        core_req_ready;
   logic        core_resp_valid;
   logic [63:0] core_resp_data;
   logic        mmu_use_dcache;
   logic [63:0] mmu_req_addr;
   logic        mmu_resp_valid;
   logic [63:0] mmu_resp_data;
   logic        dc_req_valid;
   logic [63:0] dc_req_addr;
   logic        dc_req_we;
   logic [63:0] dc_req_wdata;
   logic        dc_req_phys;
   logic        dc_req_ready;
   logic        dc_resp_valid;
   logic [63:0] dc_resp_data;
   logic        arb_timeout;

   int checks = 0;
   int errors = 0;

`ifdef DCARB_WATCHDOG_EN
   localparam logic TIMEOUT_EXP = 1'b1;
`else
   localparam logic TIMEOUT_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   dcache_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .core_req_valid (core_req_valid),
      .core_req_addr  (core_req_addr),
      .core_req_we    (core_req_we),
      .core_req_wdata (core_req_wdata),
      .core_req_ready (core_req_ready),
      .core_resp_valid(core_resp_valid),
      .core_resp_data (core_resp_data),
      .mmu_use_dcache (mmu_use_dcache),
      .mmu_req_addr   (mmu_req_addr),
      .mmu_resp_valid (mmu_resp_valid),
      .mmu_resp_data  (mmu_resp_data),
      .dc_req_valid   (dc_req_valid),
      .dc_req_addr    (dc_req_addr),
      .dc_req_we      (dc_req_we),
      .dc_req_wdata   (dc_req_wdata),
      .dc_req_phys    (dc_req_phys),
      .dc_req_ready   (dc_req_ready),
      .dc_resp_valid  (dc_resp_valid),
      .dc_resp_data   (dc_resp_data),
      .arb_timeout    (arb_timeout)
   );

   typedef struct {
      logic        cv;
      logic [63:0] ca;
      logic        we;
      logic [63:0] wd;
      logic        mu;
      logic [63:0] ma;
      logic        rdy;
      logic        rv;
      logic [63:0] rd;
      logic        x_cr;
      logic        x_crv;
      logic        x_mrv;
      logic [63:0] x_rd;
      logic        x_dv;
      logic [63:0] x_da;
      logic        x_dp;
      logic        x_dwe;
      logic [63:0] x_dwd;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   // Model of the port: who owns the outstanding request, and whether the walker still holds the port.
   int m_owner;
   bit m_hold;

   // Global watchdog so a hung simulation still terminates with a failure message.
   initial begin
      #400000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core_req_valid = 1'b0;
      core_req_addr  = '0;
      core_req_we    = 1'b0;
      core_req_wdata = '0;
      mmu_use_dcache = 1'b0;
      mmu_req_addr   = '0;
      dc_req_ready   = 1'b1;
      dc_resp_valid  = 1'b0;
      dc_resp_data   = '0;
   endtask

   task automatic applyStimulus(input vec_t v);
      core_req_valid = v.cv;
      core_req_addr  = v.ca;
      core_req_we    = v.we;
      core_req_wdata = v.wd;
      mmu_use_dcache = v.mu;
      mmu_req_addr   = v.ma;
      dc_req_ready   = v.rdy;
      dc_resp_valid  = v.rv;
      dc_resp_data   = v.rd;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      check1($sformatf("v%0d_core_req_ready", idx), core_req_ready, v.x_cr);
      check1($sformatf("v%0d_core_resp_valid", idx), core_resp_valid, v.x_crv);
      check1($sformatf("v%0d_mmu_resp_valid", idx), mmu_resp_valid, v.x_mrv);
      check1($sformatf("v%0d_dc_req_valid", idx), dc_req_valid, v.x_dv);
      check64($sformatf("v%0d_dc_req_addr", idx), dc_req_addr, v.x_da);
      check1($sformatf("v%0d_dc_req_phys", idx), dc_req_phys, v.x_dp);
      check1($sformatf("v%0d_dc_req_we", idx), dc_req_we, v.x_dwe);
      check64($sformatf("v%0d_dc_req_wdata", idx), dc_req_wdata, v.x_dwd);
      if (v.x_crv) check64($sformatf("v%0d_core_resp_data", idx), core_resp_data, v.x_rd);
      if (v.x_mrv) check64($sformatf("v%0d_mmu_resp_data", idx), mmu_resp_data, v.x_rd);
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, "_core_req_ready"}, core_req_ready, 1'b0);
      check1({tag, "_core_resp_valid"}, core_resp_valid, 1'b0);
      check64({tag, "_core_resp_data"}, core_resp_data, 64'h0);
      check1({tag, "_mmu_resp_valid"}, mmu_resp_valid, 1'b0);
      check64({tag, "_mmu_resp_data"}, mmu_resp_data, 64'h0);
      check1({tag, "_dc_req_valid"}, dc_req_valid, 1'b0);
      check64({tag, "_dc_req_addr"}, dc_req_addr, 64'h0);
      check1({tag, "_dc_req_we"}, dc_req_we, 1'b0);
      check64({tag, "_dc_req_wdata"}, dc_req_wdata, 64'h0);
      check1({tag, "_dc_req_phys"}, dc_req_phys, 1'b0);
      check1({tag, "_arb_timeout"}, arb_timeout, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      next_cycle();
      reset = 1'b0;
   endtask

   // Main test sequence: directed vectors, walk, stall, reset, watchdog and random traffic.
   initial begin
      // cv ca we wd | mu ma | rdy rv rd | cr crv mrv rd | dv da dp dwe dwd
      vecs[0]  = '{1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,
                   1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0};
      vecs[1]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[2]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[3]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hAB,
                   1'b0, 1'b1, 1'b0, 64'hAB, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[4]  = '{1'b1, 64'h2000, 1'b0, 64'h0, 1'b1, 64'h8000_0018, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0018, 1'b1, 1'b0, 64'h0};
      vecs[5]  = '{1'b1, 64'h2000, 1'b0, 64'h0, 1'b1, 64'h8000_0018, 1'b1, 1'b1, 64'h55,
                   1'b0, 1'b0, 1'b1, 64'h55, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[6]  = '{1'b1, 64'h2000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[7]  = '{1'b1, 64'h2000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,
                   1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h2000, 1'b0, 1'b0, 64'h0};
      vecs[8]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3000, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[9]  = vecs[8];
      vecs[10] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3000, 1'b1, 1'b1, 64'h77,
                   1'b0, 1'b1, 1'b0, 64'h77, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[11] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3000, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h3000, 1'b1, 1'b0, 64'h0};
      vecs[12] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3000, 1'b1, 1'b1, 64'h99,
                   1'b0, 1'b0, 1'b1, 64'h99, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[13] = '{1'b1, 64'h4000, 1'b1, 64'hDEAD, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[14] = '{1'b1, 64'h4000, 1'b1, 64'hDEAD, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4000, 1'b0, 1'b1, 64'hDEAD};
      vecs[15] = '{1'b1, 64'h4000, 1'b1, 64'hDEAD, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,
                   1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4000, 1'b0, 1'b1, 64'hDEAD};
      vecs[16] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h1234,
                   1'b0, 1'b1, 1'b0, 64'h1234, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
      vecs[17] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hFF,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};

      // Reset state, with a walker request held on the inputs to show outputs stay quiet.
      reset = 1'b1;
      idle_inputs();
      mmu_use_dcache = 1'b1;
      mmu_req_addr   = 64'h1234;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      next_cycle();
      idle_inputs();
      reset = 1'b0;

      // Directed vectors: core read, simultaneous requests, walker waiting on core, core write, spurious response.
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(i, vecs[i]);
         next_cycle();
      end
      idle_inputs();
      next_cycle();

      // 4-level walk, each PTE returned two cycles after its accept.
      begin
         int n_acc = 0;
         int n_resp = 0;
         int since = -1;
         bit attr_ok = 1'b1;
         for (int c = 0; c < 40 && n_resp < 4; c++) begin
            mmu_use_dcache = 1'b1;
            mmu_req_addr   = 64'h9000 + 64'(n_resp * 8);
            dc_req_ready   = 1'b1;
            dc_resp_valid  = (since == 2);
            dc_resp_data   = 64'hA0 + 64'(n_resp);
            @(negedge clk);
            if (dc_req_valid && dc_req_ready) begin
               n_acc++;
               if (!dc_req_phys || dc_req_we || dc_req_addr != 64'h9000 + 64'(n_resp * 8))
                  attr_ok = 1'b0;
            end
            if (mmu_resp_valid) begin
               check64("walk_pte_data", mmu_resp_data, 64'hA0 + 64'(n_resp));
               n_resp++;
            end
            if (dc_resp_valid) since = -1;
            else if (dc_req_valid && dc_req_ready) since = 0;
            else if (since >= 0) since++;
            next_cycle();
         end
         check64("walk_accepts", 64'(n_acc), 64'd4);
         check64("walk_resps", 64'(n_resp), 64'd4);
         check1("walk_phys_read_attrs", attr_ok, 1'b1);
         idle_inputs();
         core_req_valid = 1'b1;
         core_req_addr  = 64'h5000;
         @(negedge clk);
         check1("walk_drop_bubble_valid", dc_req_valid, 1'b0);
         check1("walk_drop_bubble_ready", core_req_ready, 1'b0);
         next_cycle();
         @(negedge clk);
         check1("walk_then_idle_core_ready", core_req_ready, 1'b1);
         check64("walk_then_idle_core_addr", dc_req_addr, 64'h5000);
         next_cycle();
         idle_inputs();
         dc_resp_valid = 1'b1;
         dc_resp_data  = 64'hC0;
         @(negedge clk);
         check1("walk_then_core_resp", core_resp_valid, 1'b1);
         next_cycle();
         idle_inputs();
      end

      // D$ stalls the walker for five cycles; the core keeps asking and must be ignored.
      mmu_use_dcache = 1'b1;
      mmu_req_addr   = 64'hA000;
      core_req_valid = 1'b1;
      core_req_addr  = 64'h6000;
      dc_req_ready   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check1($sformatf("stall%0d_valid", i), dc_req_valid, 1'b1);
         check64($sformatf("stall%0d_addr", i), dc_req_addr, 64'hA000);
         check1($sformatf("stall%0d_phys", i), dc_req_phys, 1'b1);
         check1($sformatf("stall%0d_core_ready", i), core_req_ready, 1'b0);
         next_cycle();
      end
      dc_req_ready = 1'b1;
      @(negedge clk);
      check1("stall_accept_valid", dc_req_valid, 1'b1);
      next_cycle();
      mmu_use_dcache = 1'b0;
      dc_resp_valid  = 1'b1;
      dc_resp_data   = 64'hBB;
      @(negedge clk);
      check1("dropped_walk_resp_mmu", mmu_resp_valid, 1'b0);
      check1("dropped_walk_resp_core", core_resp_valid, 1'b0);
      check1("dropped_walk_resp_req", dc_req_valid, 1'b0);
      next_cycle();
      dc_resp_valid = 1'b0;
      @(negedge clk);
      check1("after_drop_idle_core_ready", core_req_ready, 1'b1);
      next_cycle();
      idle_inputs();
      dc_resp_valid = 1'b1;
      @(negedge clk);
      check1("after_drop_core_resp", core_resp_valid, 1'b1);
      next_cycle();
      idle_inputs();

      // Reset during WALK_WAIT, then a late response that must be dropped.
      mmu_use_dcache = 1'b1;
      mmu_req_addr   = 64'hC000;
      @(negedge clk);
      check1("pre_reset_walk_accept", dc_req_valid, 1'b1);
      next_cycle();
      reset = 1'b1;
      dc_resp_valid = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      next_cycle();
      reset = 1'b0;
      idle_inputs();
      dc_resp_valid = 1'b1;
      dc_resp_data  = 64'hEE;
      @(negedge clk);
      check_all_zero("late_resp");
      next_cycle();
      idle_inputs();

      // Withheld core response: watchdog (if built) fires after eight wait cycles and stays set.
      core_req_valid = 1'b1;
      core_req_addr  = 64'h7000;
      @(negedge clk);
      check1("wd_accept", core_req_ready, 1'b1);
      next_cycle();
      idle_inputs();
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 8) check1("wd_before_limit", arb_timeout, 1'b0);
         if (k == 9) check1("wd_at_limit", arb_timeout, TIMEOUT_EXP);
         next_cycle();
      end
      dc_resp_valid = 1'b1;
      @(negedge clk);
      check1("wd_late_core_resp", core_resp_valid, 1'b1);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check1("wd_sticky", arb_timeout, TIMEOUT_EXP);
      next_cycle();
      do_reset();
      @(negedge clk);
      check1("wd_cleared_by_reset", arb_timeout, 1'b0);
      next_cycle();

      // Randomized traffic against the ownership model.
      m_owner = 0;
      m_hold  = 1'b0;
      for (int c = 0; c < 600; c++) begin
         logic e_cr, e_crv, e_mrv, e_dv, e_dp, e_dwe;
         logic [63:0] e_da, e_dwd;
         int n_owner;
         bit n_hold;

         core_req_valid = 1'($urandom_range(0, 1));
         core_req_addr  = {$urandom, $urandom};
         core_req_we    = 1'($urandom_range(0, 1));
         core_req_wdata = {$urandom, $urandom};
         if (mmu_use_dcache) mmu_use_dcache = ($urandom_range(0, 7) != 0);
         else                mmu_use_dcache = ($urandom_range(0, 3) == 0);
         if (m_owner != 2) mmu_req_addr = {$urandom, $urandom};
         dc_req_ready   = ($urandom_range(0, 3) != 0);
         dc_resp_valid  = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         dc_resp_data   = {$urandom, $urandom};

         e_cr = 0; e_crv = 0; e_mrv = 0; e_dv = 0; e_dp = 0; e_dwe = 0;
         e_da = '0; e_dwd = '0;
         n_owner = m_owner;
         n_hold  = m_hold;
         if (m_owner != 0) begin
            if (dc_resp_valid) begin
               if (m_owner == 1) e_crv = 1'b1;
               else              e_mrv = mmu_use_dcache;
               n_hold  = (m_owner == 2) && mmu_use_dcache;
               n_owner = 0;
            end
         end else if (mmu_use_dcache) begin
            e_dv = 1'b1; e_dp = 1'b1; e_da = mmu_req_addr;
            if (dc_req_ready) begin n_owner = 2; n_hold = 1'b0; end
            else n_hold = 1'b1;
         end else if (m_hold) begin
            n_hold = 1'b0;
         end else if (core_req_valid) begin
            e_dv = 1'b1; e_da = core_req_addr; e_dwe = core_req_we; e_dwd = core_req_wdata;
            e_cr = dc_req_ready;
            if (dc_req_ready) n_owner = 1;
         end

         @(negedge clk);
         check1("rnd_core_req_ready", core_req_ready, e_cr);
         check1("rnd_core_resp_valid", core_resp_valid, e_crv);
         check1("rnd_mmu_resp_valid", mmu_resp_valid, e_mrv);
         check1("rnd_dc_req_valid", dc_req_valid, e_dv);
         check64("rnd_dc_req_addr", dc_req_addr, e_da);
         check1("rnd_dc_req_phys", dc_req_phys, e_dp);
         check1("rnd_dc_req_we", dc_req_we, e_dwe);
         check64("rnd_dc_req_wdata", dc_req_wdata, e_dwd);
         if (e_crv) check64("rnd_core_resp_data", core_resp_data, dc_resp_data);
         if (e_mrv) check64("rnd_mmu_resp_data", mmu_resp_data, dc_resp_data);
         m_owner = n_owner;
         m_hold  = n_hold;
         next_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
